multi_mode_ff_bank: RTL and testbench
=====================================

MULTI_MODE_FF_BANK -- requirements
Module: multi_mode_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent flip-flop bits.
REQ-002 SHALL have parameter INVALID_POLICY, default 0, SR S=R=1 resolution (0 hold, 1 reset-dominant, 2 set-dominant, 3 toggle).
REQ-003 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-004 SHALL have parameter ERR_CNT_W, default 8, width of err_count.
REQ-005 SHALL have port clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  update enable for the functional modes.
REQ-008 SHALL have port mode  input  2  bank type: 00 SR, 01 JK, 10 D, 11 T; applies to all bits in that cycle.
REQ-009 SHALL have port a  input  WIDTH  per-bit S / J / D / T operand.
REQ-010 SHALL have port b  input  WIDTH  per-bit R / K operand; ignored in D and T modes.
REQ-011 SHALL have port load  input  1  parallel load strobe.
REQ-012 SHALL have port load_val  input  WIDTH  parallel load data.
REQ-013 SHALL have port clr_err  input  1  clears err_sticky and err_count.
REQ-014 SHALL have port q  output  WIDTH  registered state.
REQ-015 SHALL have port q_n  output  WIDTH  bitwise inverse of q, always ~q.
REQ-016 SHALL have port changed  output  WIDTH  registered per-bit flag: bit of q changed at the last edge.
REQ-017 SHALL have port invalid_mask  output  WIDTH  registered per-bit flag: SR S=R=1 sampled at the last edge.
REQ-018 SHALL have port err_sticky  output  1  set by any invalid event, held until clr_err or rst.
REQ-019 SHALL have port err_count  output  ERR_CNT_W  saturating count of cycles containing at least one invalid bit.

Function
REQ-020 SHALL apply priority per edge: rst > load > en > hold.
REQ-021 SHALL, on load=1 (rst=0), set q=load_val regardless of en and mode; invalid_mask=0; no error event.
REQ-022 SHALL, with en=0 and load=0, hold q; invalid_mask=0; changed=0.
REQ-023 SHALL, in SR mode with en=1, per bit: 00 hold, 01 clear, 10 set, 11 resolve per INVALID_POLICY and set invalid_mask bit.
REQ-024 SHALL, in JK mode with en=1, per bit: 00 hold, 01 clear, 10 set, 11 toggle; never invalid.
REQ-025 SHALL, in D mode with en=1, set q=a.
REQ-026 SHALL, in T mode with en=1, set q=q^a.
REQ-027 SHALL never drive X onto q; the S=R=1 case resolves deterministically.
REQ-028 SHALL register changed = q_next ^ q on every non-reset edge, including load edges.
REQ-029 SHALL treat a cycle as an invalid event when invalid_mask_next is non-zero; err_count increments by exactly 1 per such cycle regardless of bit count.
REQ-030 SHALL saturate err_count at 2^ERR_CNT_W-1; no wrap.
REQ-031 SHALL, on clr_err without invalid event, clear err_sticky and err_count at the edge.
REQ-032 SHALL, on clr_err coincident with an invalid event, leave err_sticky=1 and err_count=1 (new event wins).
REQ-033 SHALL give one-cycle latency: inputs sampled at edge N are reflected on all outputs after edge N.
REQ-034 SHALL allow mode to change every cycle with no pipeline or settling delay.

Reset
REQ-035 SHALL, on rst=1 at an edge, set q=RST_VAL, changed=0, invalid_mask=0, err_sticky=0, err_count=0, ignoring load, en, clr_err.
REQ-036 SHALL, on rst asserted mid-operation, discard that cycle's update and error event completely.

Verification
REQ-037 SHALL cover WIDTH=8, SR mode, q=0x0F, a=0xF0, b=0x0F, en=1 -> q=0xF0, changed=0xFF, invalid_mask=0.
REQ-038 SHALL cover INVALID_POLICY=0, SR, q=0xAA, a=b=0x03 -> q=0xAA, invalid_mask=0x03, err_sticky=1, err_count=1; repeat for policies 1/2/3 -> q=0xA8/0xAB/0xA9.
REQ-039 SHALL cover JK mode, q=0x55, a=b=0xFF -> q=0xAA, invalid_mask=0, err_count unchanged.
REQ-040 SHALL cover load=1, en=0, load_val=0x3C over T mode with a=0xFF -> q=0x3C; next cycle en=1, load=0 -> q=0xC3.
REQ-041 SHALL cover ERR_CNT_W=2, four consecutive invalid cycles -> err_count 1,2,3,3; then clr_err with invalid -> err_count=1, err_sticky=1.
REQ-042 SHALL cover rst=1 with load=1, clr_err=0, invalid inputs -> q=RST_VAL, all flags 0, err_count=0.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops that can act as SR, JK, D or T bits, selected per cycle by mode.
// It also has a parallel load, a per-bit change/invalid flag and a saturating SR-conflict counter.
module multi_mode_ff_bank #(
  parameter int unsigned       WIDTH          = 8,
  parameter int unsigned       INVALID_POLICY = 0,
  parameter logic [WIDTH-1:0]  RST_VAL        = {WIDTH{1'b0}},
  parameter int unsigned       ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_n,
  output logic [WIDTH-1:0]     changed,
  output logic [WIDTH-1:0]     invalid_mask,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ModeSr = 2'b00,
    ModeJk = 2'b01,
    ModeD  = 2'b10,
    ModeT  = 2'b11
  } mode_e;

  localparam logic [ERR_CNT_W-1:0] CntMax = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CntOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     changed_q, changed_d;
  logic [WIDTH-1:0]     invalid_q, invalid_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  mode_e            mode_sel;
  logic [WIDTH-1:0] sr_both;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_resolved;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] func_next;
  logic [WIDTH-1:0] func_invalid;
  logic [WIDTH-1:0] q_next;
  logic             err_event;

  assign mode_sel = mode_e'(mode);

  // SR: 00 hold, 01 clear, 10 set; the 11 bits are overridden by the policy value below.
  always_comb begin
    sr_both = a & b;
    sr_base = (q_q | a) & ~b;
    sr_resolved = q_q;
    case (INVALID_POLICY)
      1:       sr_resolved = {WIDTH{1'b0}};
      2:       sr_resolved = {WIDTH{1'b1}};
      3:       sr_resolved = ~q_q;
      default: sr_resolved = q_q;
    endcase
    sr_next = (sr_base & ~sr_both) | (sr_resolved & sr_both);
    jk_next = (a & ~q_q) | (~b & q_q);
  end

  always_comb begin
    func_next    = q_q;
    func_invalid = {WIDTH{1'b0}};
    case (mode_sel)
      ModeSr: begin
        func_next    = sr_next;
        func_invalid = sr_both;
      end
      ModeJk:  func_next = jk_next;
      ModeD:   func_next = a;
      ModeT:   func_next = q_q ^ a;
      default: func_next = q_q;
    endcase
  end

  // Priority below reset: load, then enable, then hold.
  always_comb begin
    q_next    = q_q;
    invalid_d = {WIDTH{1'b0}};
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next    = func_next;
      invalid_d = func_invalid;
    end
    if (rst) begin
      invalid_d = {WIDTH{1'b0}};
    end
  end

  assign err_event = |invalid_d;

  always_comb begin
    q_d          = q_next;
    changed_d    = q_next ^ q_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (rst) begin
      q_d          = RST_VAL;
      changed_d    = {WIDTH{1'b0}};
      err_sticky_d = 1'b0;
      err_count_d  = {ERR_CNT_W{1'b0}};
    end else if (err_event) begin
      // A new event on the clearing edge restarts the count at one.
      err_sticky_d = 1'b1;
      if (clr_err) begin
        err_count_d = CntOne;
      end else if (err_count_q != CntMax) begin
        err_count_d = err_count_q + CntOne;
      end
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = {ERR_CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    q_q          <= q_d;
    changed_q    <= changed_d;
    invalid_q    <= invalid_d;
    err_sticky_q <= err_sticky_d;
    err_count_q  <= err_count_d;
  end

  assign q            = q_q;
  assign q_n          = ~q_q;
  assign changed      = changed_q;
  assign invalid_mask = invalid_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Drives four policy variants and one narrow-counter variant of the bank with shared stimulus.
// Each variant is compared every cycle against a per-bit behavioural model.
module tb_multi_mode_ff_bank;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       clr_err = 1'b0;

  logic [7:0] o_q   [NI];
  logic [7:0] o_qn  [NI];
  logic [7:0] o_chg [NI];
  logic [7:0] o_inv [NI];
  logic       o_st  [NI];
  logic [7:0] o_cnt [4];
  logic [1:0] o_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pol
    multi_mode_ff_bank #(
      .WIDTH(8), .INVALID_POLICY(g), .RST_VAL(8'h00), .ERR_CNT_W(8)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
      .load_val(load_val), .clr_err(clr_err), .q(o_q[g]), .q_n(o_qn[g]),
      .changed(o_chg[g]), .invalid_mask(o_inv[g]), .err_sticky(o_st[g]),
      .err_count(o_cnt[g])
    );
  end

  multi_mode_ff_bank #(
    .WIDTH(8), .INVALID_POLICY(0), .RST_VAL(8'h00), .ERR_CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .load_val(load_val), .clr_err(clr_err), .q(o_q[4]), .q_n(o_qn[4]),
    .changed(o_chg[4]), .invalid_mask(o_inv[4]), .err_sticky(o_st[4]),
    .err_count(o_cnt_s)
  );

  function automatic logic [7:0] cnt_of(int k);
    if (k < 4) return o_cnt[k];
    return {6'b0, o_cnt_s};
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
    end
  endtask

  // Behavioural model: returns {invalid_bits, next_q} for one enabled functional update.
  function automatic logic [15:0] model_step(logic [1:0] md, logic [7:0] cq, logic [7:0] sa,
                                             logic [7:0] sb, int pol);
    logic [7:0] nq;
    logic [7:0] inv;
    nq  = cq;
    inv = 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'd0: begin
          if (sa[i] && sb[i]) begin
            inv[i] = 1'b1;
            if (pol == 1) nq[i] = 1'b0;
            else if (pol == 2) nq[i] = 1'b1;
            else if (pol == 3) nq[i] = ~cq[i];
          end else if (sa[i]) nq[i] = 1'b1;
          else if (sb[i]) nq[i] = 1'b0;
        end
        2'd1: begin
          if (sa[i] && sb[i]) nq[i] = ~cq[i];
          else if (sa[i]) nq[i] = 1'b1;
          else if (sb[i]) nq[i] = 1'b0;
        end
        2'd2: nq[i] = sa[i];
        default: nq[i] = cq[i] ^ sa[i];
      endcase
    end
    return {inv, nq};
  endfunction

  logic [7:0] m_q   [NI];
  logic [7:0] m_chg [NI];
  logic [7:0] m_inv [NI];
  logic       m_st  [NI];
  int         m_cnt [NI];
  bit         m_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int         pol;
      int         cap;
      logic [15:0] r;
      logic [7:0] nq;
      logic [7:0] ninv;
      pol = (k < 4) ? k : 0;
      cap = (k < 4) ? 255 : 3;
      if (rst) begin
        m_q[k] = 8'h00; m_chg[k] = 8'h00; m_inv[k] = 8'h00; m_st[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        nq   = m_q[k];
        ninv = 8'h00;
        if (load) begin
          nq = load_val;
        end else if (en) begin
          r    = model_step(mode, m_q[k], a, b, pol);
          nq   = r[7:0];
          ninv = r[15:8];
        end
        m_chg[k] = nq ^ m_q[k];
        m_inv[k] = ninv;
        if (ninv != 8'h00) begin
          m_st[k]  = 1'b1;
          m_cnt[k] = clr_err ? 1 : ((m_cnt[k] + 1 > cap) ? cap : m_cnt[k] + 1);
        end else if (clr_err) begin
          m_st[k]  = 1'b0;
          m_cnt[k] = 0;
        end
        m_q[k] = nq;
      end
    end
    if (rst) m_ok = 1'b1;
    #1;
    if (m_ok) begin
      for (int k = 0; k < NI; k++) begin
        chk("q", k, {24'b0, o_q[k]}, {24'b0, m_q[k]});
        chk("q_n", k, {24'b0, o_qn[k]}, {24'b0, ~m_q[k]});
        chk("changed", k, {24'b0, o_chg[k]}, {24'b0, m_chg[k]});
        chk("invalid_mask", k, {24'b0, o_inv[k]}, {24'b0, m_inv[k]});
        chk("err_sticky", k, {31'b0, o_st[k]}, {31'b0, m_st[k]});
        chk("err_count", k, {24'b0, cnt_of(k)}, m_cnt[k]);
      end
    end
  end

  // Apply one cycle of inputs; returns after the edge, at the following falling edge.
  task automatic cyc(logic r, logic e, logic [1:0] md, logic [7:0] va, logic [7:0] vb,
                     logic ld, logic [7:0] lv, logic ce);
    rst = r; en = e; mode = md; a = va; b = vb; load = ld; load_val = lv; clr_err = ce;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_reset_q", 0, {24'b0, o_q[0]}, 32'h00);
    chk("lit_reset_qn", 0, {24'b0, o_qn[0]}, 32'hFF);
    chk("lit_reset_cnt", 0, {24'b0, cnt_of(0)}, 32'h0);

    cyc(0, 0, 0, 0, 0, 1, 8'h0F, 0);
    cyc(0, 1, 2'b00, 8'hF0, 8'h0F, 0, 0, 0);
    chk("lit_sr_q", 0, {24'b0, o_q[0]}, 32'hF0);
    chk("lit_sr_changed", 0, {24'b0, o_chg[0]}, 32'hFF);
    chk("lit_sr_inv", 0, {24'b0, o_inv[0]}, 32'h00);

    cyc(0, 0, 0, 0, 0, 1, 8'hAA, 1);
    cyc(0, 1, 2'b00, 8'h03, 8'h03, 0, 0, 0);
    chk("lit_pol0_q", 0, {24'b0, o_q[0]}, 32'hAA);
    chk("lit_pol1_q", 1, {24'b0, o_q[1]}, 32'hA8);
    chk("lit_pol2_q", 2, {24'b0, o_q[2]}, 32'hAB);
    chk("lit_pol3_q", 3, {24'b0, o_q[3]}, 32'hA9);
    chk("lit_pol_inv", 0, {24'b0, o_inv[0]}, 32'h03);
    chk("lit_pol_sticky", 0, {31'b0, o_st[0]}, 32'h1);
    chk("lit_pol_cnt", 0, {24'b0, cnt_of(0)}, 32'h1);

    cyc(0, 0, 0, 0, 0, 1, 8'h55, 0);
    cyc(0, 1, 2'b01, 8'hFF, 8'hFF, 0, 0, 0);
    chk("lit_jk_q", 0, {24'b0, o_q[0]}, 32'hAA);
    chk("lit_jk_inv", 0, {24'b0, o_inv[0]}, 32'h00);
    chk("lit_jk_cnt", 0, {24'b0, cnt_of(0)}, 32'h1);

    cyc(0, 0, 2'b11, 8'hFF, 0, 1, 8'h3C, 0);
    chk("lit_load_q", 0, {24'b0, o_q[0]}, 32'h3C);
    cyc(0, 1, 2'b11, 8'hFF, 0, 0, 0, 0);
    chk("lit_toggle_q", 0, {24'b0, o_q[0]}, 32'hC3);

    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 4; n++) begin
      logic [1:0] exp_sat [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      cyc(0, 1, 2'b00, 8'h01, 8'h01, 0, 0, 0);
      chk("lit_sat_cnt", 4, {30'b0, o_cnt_s}, {30'b0, exp_sat[n]});
    end
    cyc(0, 1, 2'b00, 8'h01, 8'h01, 0, 0, 1);
    chk("lit_clr_inv_cnt", 4, {30'b0, o_cnt_s}, 32'h1);
    chk("lit_clr_inv_sticky", 4, {31'b0, o_st[4]}, 32'h1);

    cyc(1, 1, 2'b00, 8'hFF, 8'hFF, 1, 8'h77, 0);
    chk("lit_rst_q", 1, {24'b0, o_q[1]}, 32'h00);
    chk("lit_rst_inv", 1, {24'b0, o_inv[1]}, 32'h00);
    chk("lit_rst_changed", 1, {24'b0, o_chg[1]}, 32'h00);
    chk("lit_rst_sticky", 1, {31'b0, o_st[1]}, 32'h0);
    chk("lit_rst_cnt", 1, {24'b0, cnt_of(1)}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
          ra, rb, ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
